// File: rtl/ov7670_capture_scaler.sv
// rtl/ov7670_capture_scaler.sv - OV7670 byte stream to framebuffer writes with RGB888 expansion and decimation
// Optional CAP_STATS_EN adds oframe_cnt/oerr_cnt frame statistics ports.
module ov7670_capture_scaler #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 19,
  parameter int OUT_W  = 24
) (
  input  logic              iclk,
  input  logic              ireset,
  input  logic              istart,
  input  logic              icontinuous,
  input  logic [1:0]        idecim,
  input  logic              ivsync,
  input  logic              ihref,
  input  logic [DATA_W-1:0] idata,
  output logic              owr_en,
  output logic [ADDR_W-1:0] oaddr,
  output logic [OUT_W-1:0]  odata_out,
  output logic              obusy,
  output logic              oframe_done,
  output logic              ogeom_err
`ifdef CAP_STATS_EN
  ,
  output logic [15:0]       oframe_cnt,
  output logic [15:0]       oerr_cnt
`endif
);

  localparam int X_W = $clog2(H_RES + 1) + 1;
  localparam int Y_W = $clog2(V_RES + 1) + 1;
  localparam logic [X_W-1:0] H_LIM = X_W'(H_RES);
  localparam logic [Y_W-1:0] V_LIM = Y_W'(V_RES);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_ACTIVE, S_DONE} state_t;

  state_t            state_q, state_d;
  logic              vsync_q, href_q, vs_prev_q, href_prev_q;
  logic [DATA_W-1:0] data_q;
  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic              phase_q, phase_d;
  logic [7:0]        hi_q, hi_d;
  logic [1:0]        decim_q, decim_d;
  logic [ADDR_W-1:0] wcnt_q, wcnt_d;
  logic              full_q, full_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [OUT_W-1:0]  odata_q, odata_d;
  logic              err_q, err_d;

  logic       vs_fall, vs_rise, href_fall, keep;
  logic [1:0] mask;
  logic [4:0] r5, b5;
  logic [5:0] g6;
  logic [7:0] r8, g8, b8;

  assign vs_fall   = vs_prev_q & ~vsync_q;
  assign vs_rise   = ~vs_prev_q & vsync_q;
  assign href_fall = href_prev_q & ~href_q;

  assign r5 = hi_q[7:3];
  assign g6 = {hi_q[2:0], data_q[7:5]};
  assign b5 = data_q[4:0];
  assign r8 = {r5, r5[4:2]};
  assign g8 = {g6, g6[5:4]};
  assign b8 = {b5, b5[4:2]};

  // Decimation 3 behaves as 1:4, so the mask only ever needs the two low bits.
  assign mask = (decim_q == 2'd0) ? 2'b00 : (decim_q == 2'd1) ? 2'b01 : 2'b11;
  assign keep = ((x_q[1:0] & mask) == 2'b00) && ((y_q[1:0] & mask) == 2'b00);

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    phase_d     = phase_q;
    hi_d        = hi_q;
    decim_d     = decim_q;
    wcnt_d      = wcnt_q;
    full_d      = full_q;
    wr_d        = 1'b0;
    addr_d      = addr_q;
    odata_d     = odata_q;
    err_d       = err_q;
    obusy       = (state_q != S_IDLE);
    oframe_done = (state_q == S_DONE);
    case (state_q)
      S_IDLE: begin
        if (istart) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (vs_fall) begin
          state_d = S_ACTIVE;
          x_d     = '0;
          y_d     = '0;
          phase_d = 1'b0;
          wcnt_d  = '0;
          full_d  = 1'b0;
          addr_d  = '0;
          decim_d = idecim;
          err_d   = 1'b0;
        end
      end
      S_ACTIVE: begin
        if (vs_rise) begin
          state_d = S_DONE;
          if (y_q != V_LIM) err_d = 1'b1;
        end else if (href_q) begin
          phase_d = ~phase_q;
          if (!phase_q) begin
            hi_d = data_q[7:0];
          end else begin
            if (x_q >= H_LIM || y_q >= V_LIM) begin
              err_d = 1'b1;
            end else if (keep) begin
              wr_d    = 1'b1;
              odata_d = OUT_W'({r8, g8, b8});
              addr_d  = wcnt_q;
              // Once the top address is used, later writes pile onto it and flag an error.
              if (full_q) err_d = 1'b1;
              if (&wcnt_q) full_d = 1'b1;
              else wcnt_d = wcnt_q + 1'b1;
            end
            if (!(&x_q)) x_d = x_q + 1'b1;
          end
        end else if (href_fall) begin
          if (x_q != H_LIM || phase_q) err_d = 1'b1;
          x_d     = '0;
          phase_d = 1'b0;
          if (!(&y_q)) y_d = y_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = icontinuous ? S_ARMED : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iclk) begin
    if (!ireset) begin
      state_q     <= S_IDLE;
      vsync_q     <= 1'b0;
      href_q      <= 1'b0;
      data_q      <= '0;
      vs_prev_q   <= 1'b0;
      href_prev_q <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      phase_q     <= 1'b0;
      hi_q        <= '0;
      decim_q     <= '0;
      wcnt_q      <= '0;
      full_q      <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      odata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      vsync_q     <= ivsync;
      href_q      <= ihref;
      data_q      <= idata;
      vs_prev_q   <= vsync_q;
      href_prev_q <= href_q;
      x_q         <= x_d;
      y_q         <= y_d;
      phase_q     <= phase_d;
      hi_q        <= hi_d;
      decim_q     <= decim_d;
      wcnt_q      <= wcnt_d;
      full_q      <= full_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      odata_q     <= odata_d;
      err_q       <= err_d;
    end
  end

  assign owr_en    = wr_q;
  assign oaddr     = addr_q;
  assign odata_out = odata_q;
  assign ogeom_err = err_q;

`ifdef CAP_STATS_EN
  logic [15:0] fcnt_q, ecnt_q;

  always_ff @(posedge iclk) begin
    if (!ireset) begin
      fcnt_q <= '0;
      ecnt_q <= '0;
    end else if (state_q == S_DONE) begin
      fcnt_q <= fcnt_q + 16'd1;
      if (err_q && ecnt_q != 16'hFFFF) ecnt_q <= ecnt_q + 16'd1;
    end
  end

  assign oframe_cnt = fcnt_q;
  assign oerr_cnt   = ecnt_q;
`endif

endmodule

// File: tb/tb_ov7670_capture_scaler.sv
// tb/tb_ov7670_capture_scaler.sv - self-checking bench for ov7670_capture_scaler on a reduced 8x6 geometry
// Define CAP_STATS_EN to also exercise the frame statistics ports.
module tb_ov7670_capture_scaler;
  localparam int H  = 8;
  localparam int V  = 6;
  localparam int AW = 6;

  logic          iclk = 1'b0;
  logic          ireset, istart, icontinuous, ivsync, ihref;
  logic [1:0]    idecim;
  logic [7:0]    idata;
  logic          owr_en, obusy, oframe_done, ogeom_err;
  logic [AW-1:0] oaddr;
  logic [23:0]   odata_out;
`ifdef CAP_STATS_EN
  logic [15:0]   oframe_cnt, oerr_cnt;
`endif

  ov7670_capture_scaler #(.H_RES(H), .V_RES(V), .DATA_W(8), .ADDR_W(AW), .OUT_W(24)) dut (
    .iclk(iclk), .ireset(ireset), .istart(istart), .icontinuous(icontinuous),
    .idecim(idecim), .ivsync(ivsync), .ihref(ihref), .idata(idata),
    .owr_en(owr_en), .oaddr(oaddr), .odata_out(odata_out), .obusy(obusy),
    .oframe_done(oframe_done), .ogeom_err(ogeom_err)
`ifdef CAP_STATS_EN
    , .oframe_cnt(oframe_cnt), .oerr_cnt(oerr_cnt)
`endif
  );

  always #5 iclk = ~iclk;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int wr_cnt = 0;
  logic [AW-1:0] last_addr;
  logic [23:0]   last_data;
  logic [AW+23:0] exp_q[$];
  bit armed_m = 0;
  bit m_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] expand(input logic [15:0] p);
    int r, g, b;
    r = int'(p) >> 11;
    g = (int'(p) >> 5) & 63;
    b = int'(p) & 31;
    return 24'((((r << 3) | (r >> 2)) << 16) | (((g << 2) | (g >> 4)) << 8) | ((b << 3) | (b >> 2)));
  endfunction

  task automatic cyc();
    @(posedge iclk);
    #1;
  endtask

  always @(negedge iclk) begin
    if (ireset && oframe_done) done_cnt++;
    if (ireset && owr_en) begin
      logic [AW+23:0] e;
      wr_cnt++;
      last_addr = oaddr;
      last_data = odata_out;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write addr=%0h data=%0h required=none", oaddr, odata_out);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", oaddr, e[AW+23:24]);
        chk("wr_data", odata_out, e[23:0]);
      end
    end
  end

  task automatic pulse_start();
    istart = 1'b1;
    cyc();
    istart = 1'b0;
    armed_m = 1'b1;
  endtask

  task automatic drive_frame(input int nlines, input int long_line, input int odd_line,
                             input int reset_line, input bit rnd, input logic [15:0] cpix);
    bit cap, rst_hit;
    int step, na, d0, w0, len;
    logic [15:0] pix;
    cap = armed_m;
    rst_hit = 0;
    d0 = done_cnt;
    w0 = wr_cnt;
    na = 0;
    step = (idecim == 2'd0) ? 1 : (idecim == 2'd1) ? 2 : 4;
    if (cap) m_err = 0;
    ivsync = 1'b1;
    repeat (4) cyc();
    ivsync = 1'b0;
    repeat (3) cyc();
    for (int y = 0; y < nlines; y++) begin
      len = (y == long_line) ? H + 1 : H;
      ihref = 1'b1;
      for (int x = 0; x < len; x++) begin
        pix = rnd ? 16'($urandom) : cpix;
        if (y == reset_line && x == 3) ireset = 1'b0;
        idata = pix[15:8];
        cyc();
        if (y == reset_line && x == 3) begin
          chk("rst_wr_en", owr_en, 0);
          chk("rst_addr", oaddr, 0);
          chk("rst_data", odata_out, 0);
          chk("rst_busy", obusy, 0);
          chk("rst_done", oframe_done, 0);
          chk("rst_err", ogeom_err, 0);
          ireset = 1'b1;
          cap = 0;
          rst_hit = 1;
          armed_m = 0;
          m_err = 0;
          exp_q.delete();
        end
        idata = pix[7:0];
        if (cap) begin
          if (x >= H || y >= V) m_err = 1;
          else if (x % step == 0 && y % step == 0) begin
            exp_q.push_back({AW'(na), expand(pix)});
            na++;
          end
        end
        cyc();
      end
      if (y == odd_line) begin
        idata = 8'h5A;
        cyc();
        if (cap) m_err = 1;
      end
      if (cap && len != H) m_err = 1;
      ihref = 1'b0;
      repeat (3) cyc();
    end
    if (cap && nlines != V) m_err = 1;
    ivsync = 1'b1;
    repeat (6) cyc();
    chk("queue_drained", exp_q.size(), 0);
    chk("frame_done_cnt", done_cnt - d0, cap ? 1 : 0);
    if (!rst_hit) chk("write_cnt", wr_cnt - w0, na);
    if (cap) armed_m = icontinuous;
    chk("busy_after", obusy, armed_m);
    chk("geom_err", ogeom_err, m_err);
  endtask

  int w0;

  initial begin
    ireset = 1'b0; istart = 1'b0; icontinuous = 1'b0; idecim = 2'd0;
    ivsync = 1'b1; ihref = 1'b0; idata = 8'h00;
    repeat (3) cyc();
    chk("reset_wr_en", owr_en, 0);
    chk("reset_addr", oaddr, 0);
    chk("reset_busy", obusy, 0);
    chk("reset_done", oframe_done, 0);
    chk("reset_err", ogeom_err, 0);
    ireset = 1'b1;
    cyc();

    // full frame of pure red, 1:1
    pulse_start();
    chk("busy_armed", obusy, 1);
    w0 = wr_cnt;
    drive_frame(V, -1, -1, -1, 0, 16'hF800);
    chk("t1_writes", wr_cnt - w0, 48);
    chk("t1_last_addr", last_addr, 47);
    chk("t1_last_data", last_data, 24'hFF0000);

    pulse_start();
    drive_frame(V, -1, -1, -1, 0, 16'h1234);
    chk("expand_1234", last_data, 24'h1045A5);

    idecim = 2'd1;
    pulse_start();
    w0 = wr_cnt;
    drive_frame(V, -1, -1, -1, 1, 16'h0);
    chk("t2_d1_writes", wr_cnt - w0, 12);
    chk("t2_d1_last_addr", last_addr, 11);

    idecim = 2'd2;
    pulse_start();
    w0 = wr_cnt;
    drive_frame(V, -1, -1, -1, 1, 16'h0);
    chk("t2_d2_writes", wr_cnt - w0, 4);
    chk("t2_d2_last_addr", last_addr, 3);

    idecim = 2'd3;
    pulse_start();
    w0 = wr_cnt;
    drive_frame(V, -1, -1, -1, 1, 16'h0);
    chk("t2_d3_writes", wr_cnt - w0, 4);

    // single-shot: second frame ignored
    idecim = 2'd0;
    pulse_start();
    drive_frame(V, -1, -1, -1, 1, 16'h0);
    w0 = wr_cnt;
    drive_frame(V, -1, -1, -1, 1, 16'h0);
    chk("t3_single_second", wr_cnt - w0, 0);

    // continuous: both frames captured, address restarts
    icontinuous = 1'b1;
    pulse_start();
    drive_frame(V, -1, -1, -1, 1, 16'h0);
    pulse_start();
    w0 = wr_cnt;
    drive_frame(V, -1, -1, -1, 1, 16'h0);
    chk("t3_cont_second", wr_cnt - w0, 48);
    icontinuous = 1'b0;
    drive_frame(V, -1, -1, -1, 1, 16'h0);

    // long line + short frame, then a clean frame clears the error
    pulse_start();
    w0 = wr_cnt;
    drive_frame(V - 1, 0, -1, -1, 1, 16'h0);
    chk("t4_writes", wr_cnt - w0, 40);
    chk("t4_err_set", ogeom_err, 1);
    pulse_start();
    drive_frame(V, -1, -1, -1, 1, 16'h0);
    chk("t4_err_cleared", ogeom_err, 0);

    pulse_start();
    drive_frame(V, -1, 2, -1, 1, 16'h0);
    chk("odd_byte_err", ogeom_err, 1);

    // reset mid-line
    pulse_start();
    drive_frame(V, -1, -1, 1, 1, 16'h0);
    chk("t5_idle", obusy, 0);
    pulse_start();
    drive_frame(V, -1, -1, -1, 1, 16'h0);

`ifdef CAP_STATS_EN
    ireset = 1'b0;
    cyc();
    ireset = 1'b1;
    armed_m = 0;
    m_err = 0;
    cyc();
    icontinuous = 1'b1;
    pulse_start();
    repeat (3) drive_frame(V, -1, -1, -1, 1, 16'h0);
    icontinuous = 1'b0;
    drive_frame(V - 1, -1, -1, -1, 1, 16'h0);
    chk("stats_frames", oframe_cnt, 4);
    chk("stats_errs", oerr_cnt, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end
endmodule
